gray_seq_ctrl: RTL and testbench
================================

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter-free 4-bit datapath; no parameters.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a run, sampled only in IDLE.
REQ-005 stop  input  1  abort request, level-sampled each edge.
REQ-006 clear  input  1  zero the counter, honoured only in IDLE.
REQ-007 mode  input  1  0 = one-shot (stop at target), 1 = continuous.
REQ-008 target  input  4  gray-code stop value for one-shot runs.
REQ-009 div  input  2  step prescaler: one step every div+1 RUN cycles.
REQ-010 count_out  output  4  current count, gray code.
REQ-011 trig  output  1  step strobe, high in the cycle whose closing edge advances the count.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle registered pulse on one-shot completion.
REQ-014 wrap  output  1  one-cycle registered pulse when count goes gray 1000 -> 0000.

Function
REQ-015 SHALL hold an internal 4-bit binary counter bin; count_out = bin ^ (bin >> 1) at all times.
REQ-016 SHALL implement two states: IDLE, RUN; busy = (state == RUN).
REQ-017 IDLE: start=1 and stop=0 at an edge -> RUN from that edge; latch target, mode, div; clear prescaler pre to 0.
REQ-018 IDLE: start=1 and stop=1 same edge -> stay IDLE, nothing latched.
REQ-019 IDLE: clear=1 -> bin = 0 at that edge; clear and start together -> bin = 0 and run starts from 0000.
REQ-020 RUN: trig = (pre == latched div), combinational from registers; trig is 0 in IDLE.
REQ-021 RUN, trig=0: pre increments; trig=1: pre = 0, bin = bin + 1 mod 16.
REQ-022 Step latency: first trig occurs in RUN cycle div+1 after start accepted; subsequent trigs every div+1 cycles.
REQ-023 One-shot: at a trig edge where the new gray value equals latched target -> done = 1 for one cycle, state -> IDLE on that edge.
REQ-024 One-shot with target equal to count_out at start: SHALL run a full 16 steps and complete on return to that value (never immediate).
REQ-025 Continuous: never asserts done; runs until stop.
REQ-026 RUN, stop=1 at an edge -> IDLE on that edge, no step taken, bin held, no done; stop takes priority over a trig in the same cycle.
REQ-027 wrap = 1 for one cycle after any edge where bin went 1111 -> 0000; wrap and done MAY coincide.
REQ-028 start and clear in RUN SHALL be ignored; target/mode/div changes in RUN have no effect until next start.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force state IDLE, bin = 0, pre = 0, count_out = 0000, trig = 0, busy = 0, done = 0, wrap = 0.
REQ-030 Reset mid-RUN SHALL abandon the run with no done pulse; after release, block waits in IDLE for a new start.

Verification
REQ-031 Reset: assert rst=0 for 1 ns at t=0 -> all outputs 0; no activity until start.
REQ-032 One-shot, div=0, target=0110 from 0000 -> count_out 0001,0011,0010,0110 on 4 consecutive edges; trig and busy high 4 cycles; done pulse with count_out=0110; then IDLE.
REQ-033 One-shot, div=2, target=0001 -> trig in RUN cycle 3 only; done 3 cycles after start accepted; count_out=0001.
REQ-034 Continuous, div=0, from 0000 -> full sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0 (unsigned); wrap pulse at 1000->0000; stop then -> IDLE, count held, no done.
REQ-035 One-shot, target=0000 from 0000 -> 16 trigs; done and wrap on same cycle; count_out=0000.
REQ-036 Corner cases: start+stop in IDLE -> no run; clear in RUN -> ignored; clear in IDLE at count 0110 -> 0000; rst=0 mid-run at count 0011 -> immediate zeros, no done.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - gray-code step sequencer with prescaler, one-shot and continuous modes
module gray_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       mode,
    input  logic [3:0] target,
    input  logic [1:0] div,
    output logic [3:0] count_out,
    output logic       trig,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_next;
    logic [3:0] bin, bin_next;
    logic [3:0] target_q, target_next;
    logic       mode_q, mode_next;
    logic [1:0] div_q, div_next;
    logic [1:0] pre, pre_next;
    logic       done_next, wrap_next;
    logic [3:0] bin_inc, gray_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bin      <= 4'd0;
            pre      <= 2'd0;
            target_q <= 4'd0;
            mode_q   <= 1'b0;
            div_q    <= 2'd0;
            done     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_next;
            bin      <= bin_next;
            pre      <= pre_next;
            target_q <= target_next;
            mode_q   <= mode_next;
            div_q    <= div_next;
            done     <= done_next;
            wrap     <= wrap_next;
        end
    end

    always_comb begin
        state_next  = state;
        bin_next    = bin;
        pre_next    = pre;
        target_next = target_q;
        mode_next   = mode_q;
        div_next    = div_q;
        done_next   = 1'b0;
        wrap_next   = 1'b0;

        bin_inc   = bin + 4'd1;
        gray_inc  = bin_inc ^ (bin_inc >> 1);
        count_out = bin ^ (bin >> 1);
        busy      = (state == RUN);
        trig      = (state == RUN) && (pre == div_q);

        case (state)
            IDLE: begin
                if (clear)
                    bin_next = 4'd0;
                if (start && !stop) begin
                    state_next  = RUN;
                    target_next = target;
                    mode_next   = mode;
                    div_next    = div;
                    pre_next    = 2'd0;
                end
            end
            RUN: begin
                // stop wins over a pending step: bin is held and no pulses fire
                if (stop) begin
                    state_next = IDLE;
                end else if (trig) begin
                    pre_next  = 2'd0;
                    bin_next  = bin_inc;
                    wrap_next = (bin == 4'hF);
                    // comparing the post-step value makes a start-equals-target run a full lap
                    if (!mode_q && (gray_inc == target_q)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    pre_next = pre + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - directed self-checking bench for gray_seq_ctrl
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clear, mode;
    logic [3:0] target;
    logic [1:0] div;
    logic [3:0] count_out;
    logic       trig, busy, done, wrap;

    int checks = 0;
    int failures = 0;
    int trig_cnt;

    logic [3:0] gseq [16];

    gray_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .target(target), .div(div), .count_out(count_out),
        .trig(trig), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        gseq[0]  = 4'd1;  gseq[1]  = 4'd3;  gseq[2]  = 4'd2;  gseq[3]  = 4'd6;
        gseq[4]  = 4'd7;  gseq[5]  = 4'd5;  gseq[6]  = 4'd4;  gseq[7]  = 4'd12;
        gseq[8]  = 4'd13; gseq[9]  = 4'd15; gseq[10] = 4'd14; gseq[11] = 4'd10;
        gseq[12] = 4'd11; gseq[13] = 4'd9;  gseq[14] = 4'd8;  gseq[15] = 4'd0;

        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 1'b0;
        target = 4'd0; div = 2'd0;
        #1;
        check4("rst_count", count_out, 4'd0);
        check1("rst_trig", trig, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_wrap", wrap, 1'b0);
        rst = 1'b1;
        tick();
        check1("idle_busy", busy, 1'b0);
        check4("idle_count", count_out, 4'd0);

        // one-shot div=0 target 0110
        start = 1'b1; mode = 1'b0; target = 4'b0110; div = 2'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check1("os0_trig", trig, 1'b1);
            check1("os0_busy", busy, 1'b1);
            tick();
            check4("os0_count", count_out, gseq[i]);
            check1("os0_done", done, (i == 3));
        end
        check1("os0_idle", busy, 1'b0);
        tick();
        check1("os0_done_clr", done, 1'b0);
        check4("os0_hold", count_out, 4'b0110);

        // start+stop together in IDLE: no run
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check1("ss_busy", busy, 1'b0);
        tick();
        check1("ss_busy2", busy, 1'b0);

        // clear in IDLE at 0110
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check4("clr_idle", count_out, 4'd0);

        // one-shot div=2 target 0001
        start = 1'b1; mode = 1'b0; target = 4'b0001; div = 2'd2;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check1("os2_trig", trig, (c == 3));
            check1("os2_busy", busy, 1'b1);
            tick();
            check1("os2_done", done, (c == 3));
        end
        check4("os2_count", count_out, 4'b0001);
        check1("os2_idle", busy, 1'b0);

        // continuous div=0 from 0000 via clear+start; clear/div changes in RUN ignored
        clear = 1'b1; start = 1'b1; mode = 1'b1; div = 2'd0; target = 4'd3;
        tick();
        clear = 1'b0; start = 1'b0;
        check4("ct_start", count_out, 4'd0);
        check1("ct_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                clear = 1'b1; div = 2'd3; mode = 1'b0; start = 1'b1;
            end else begin
                clear = 1'b0; start = 1'b0;
            end
            tick();
            check4("ct_count", count_out, gseq[i]);
            check1("ct_wrap", wrap, (i == 15));
            check1("ct_done", done, 1'b0);
        end
        clear = 1'b0; start = 1'b0;
        tick();
        check4("ct_after", count_out, 4'd1);
        check1("ct_wrap_clr", wrap, 1'b0);
        stop = 1'b1;
        check1("ct_trig_stop", trig, 1'b1);
        tick();
        stop = 1'b0;
        check1("ct_stop_busy", busy, 1'b0);
        check4("ct_stop_hold", count_out, 4'd1);
        check1("ct_stop_done", done, 1'b0);

        // one-shot target 0000 from 0000: full lap
        clear = 1'b1; start = 1'b1; mode = 1'b0; target = 4'd0; div = 2'd0;
        tick();
        clear = 1'b0; start = 1'b0;
        trig_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (trig) trig_cnt++;
            tick();
            if (i < 15) check1("lap_done_early", done, 1'b0);
        end
        check4("lap_trigs", trig_cnt[3:0], 4'd0);
        check1("lap_trigs16", (trig_cnt == 16), 1'b1);
        check1("lap_done", done, 1'b1);
        check1("lap_wrap", wrap, 1'b1);
        check4("lap_count", count_out, 4'd0);
        check1("lap_idle", busy, 1'b0);

        // reset mid-run at 0011
        tick();
        start = 1'b1; mode = 1'b1; div = 2'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check4("mr_count", count_out, 4'b0011);
        #2;
        rst = 1'b0;
        #1;
        check4("mr_zero_count", count_out, 4'd0);
        check1("mr_zero_busy", busy, 1'b0);
        check1("mr_zero_trig", trig, 1'b0);
        check1("mr_zero_done", done, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("mr_wait_busy", busy, 1'b0);
            check1("mr_wait_done", done, 1'b0);
            check4("mr_wait_count", count_out, 4'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
